// File: rtl/mdu_iter.sv
// rtl/mdu_iter.sv - iterative RV32M multiply/divide unit, one result bit per cycle
module mdu_iter #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] src1_i,
    input  logic [XLEN-1:0] src2_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] res_o,
    output logic            zero_o
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CALC, S_FIX} state_t;

    state_t            state_q, state_d;
    logic [2:0]        op_q;
    logic [XLEN-1:0]   s1_q, s2_q;
    logic [XLEN-1:0]   hi_q, lo_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [XLEN-1:0]   res_q;
    logic              zero_q;

    logic              s1_signed, s2_signed, a_neg, b_neg;
    logic [XLEN-1:0]   abs1, abs2;
    logic [XLEN:0]     mul_sum, div_tmp, div_diff;
    logic [2*XLEN-1:0] prod, prod_neg;
    logic [XLEN-1:0]   fix_res;
    logic              div_zero, div_ovf, accept;

    // Signedness follows funct3: odd divide ops and MULHU are unsigned, MULHSU only src1 signed.
    assign s1_signed = op_q[2] ? ~op_q[0] : (op_q != 3'b011);
    assign s2_signed = op_q[2] ? ~op_q[0] : ~op_q[1];
    assign a_neg     = s1_signed & s1_q[XLEN-1];
    assign b_neg     = s2_signed & s2_q[XLEN-1];
    assign abs1      = a_neg ? -s1_q : s1_q;
    assign abs2      = b_neg ? -s2_q : s2_q;

    assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, abs2} : '0);
    assign div_tmp   = {hi_q, lo_q[XLEN-1]};
    assign div_diff  = div_tmp - {1'b0, abs2};

    assign prod      = {hi_q, lo_q};
    assign prod_neg  = -prod;
    assign div_zero  = (s2_q == '0);
    assign div_ovf   = ~op_q[0] && (s1_q == {1'b1, {(XLEN-1){1'b0}}}) && (&s2_q);

    always_comb begin
        fix_res = '0;
        case (op_q)
            3'b000:                 fix_res = (a_neg ^ b_neg) ? prod_neg[XLEN-1:0] : prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fix_res = (a_neg ^ b_neg) ? prod_neg[2*XLEN-1:XLEN] : prod[2*XLEN-1:XLEN];
            3'b100, 3'b101: begin
                if (div_zero)     fix_res = '1;
                else if (div_ovf) fix_res = s1_q;
                else              fix_res = (a_neg ^ b_neg) ? -lo_q : lo_q;
            end
            default: begin
                if (div_zero)     fix_res = s1_q;
                else if (div_ovf) fix_res = '0;
                else              fix_res = a_neg ? -hi_q : hi_q;
            end
        endcase
    end

    assign accept = start_i && !flush_i;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) state_d = S_LOAD;
            S_LOAD: state_d = flush_i ? S_IDLE : S_CALC;
            S_CALC: begin
                if (flush_i)                     state_d = S_IDLE;
                else if (cnt_q == CNT_W'(1))     state_d = S_FIX;
            end
            S_FIX:  state_d = accept ? S_LOAD : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q   <= '0;
            s1_q   <= '0;
            s2_q   <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            cnt_q  <= '0;
            res_q  <= '0;
            zero_q <= 1'b0;
        end else begin
            case (state_q)
                S_LOAD: begin
                    hi_q  <= '0;
                    lo_q  <= abs1;
                    cnt_q <= CNT_W'(XLEN);
                end
                S_CALC: begin
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (op_q[2] == 1'b0) begin
                        {hi_q, lo_q} <= {mul_sum, lo_q[XLEN-1:1]};
                    end else if (!div_diff[XLEN]) begin
                        hi_q <= div_diff[XLEN-1:0];
                        lo_q <= {lo_q[XLEN-2:0], 1'b1};
                    end else begin
                        hi_q <= div_tmp[XLEN-1:0];
                        lo_q <= {lo_q[XLEN-2:0], 1'b0};
                    end
                end
                default: ;
            endcase
            if (state_q == S_FIX && !flush_i) begin
                res_q  <= fix_res;
                zero_q <= (fix_res == '0);
            end
            // Operands are latched only on acceptance, so later input changes are ignored.
            if ((state_q == S_IDLE || state_q == S_FIX) && accept) begin
                op_q <= op_i;
                s1_q <= src1_i;
                s2_q <= src2_i;
            end
        end
    end

    assign busy_o = (state_q == S_LOAD) || (state_q == S_CALC);
    assign done_o = (state_q == S_FIX) && !flush_i;
    assign res_o  = done_o ? fix_res : res_q;
    assign zero_o = done_o ? (fix_res == '0) : zero_q;

endmodule
